// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - Z80 system bus arbiter: BUSRQ/BUSAK handshake plus round-robin grants to secondary masters
module z80_bus_arbiter #(
    parameter int MASTER_QTY = 2,
    parameter int MAX_HOLD   = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MASTER_QTY-1:0]         req,
    output logic [MASTER_QTY-1:0]         grant,
    output logic [$clog2(MASTER_QTY)-1:0] msel,
    output logic                          busrqn,
    input  logic                          busakn,
    input  logic                          bus_mreqn,
    input  logic                          bus_iorqn,
    output logic                          preempt
);
    localparam int SEL_W = $clog2(MASTER_QTY);
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [2:0] {
        CPU_OWN,
        RQ_CPU,
        GRANT,
        RELEASE,
        HANDOFF,
        CPU_RETURN
    } state_t;

    state_t                state, state_d;
    logic [MASTER_QTY-1:0] grant_d;
    logic [SEL_W-1:0]      msel_d;
    logic                  busrqn_d;
    logic                  preempt_d;
    logic [CNT_W-1:0]      hold_cnt, hold_cnt_d;
    logic [SEL_W-1:0]      ptr, ptr_d;

    logic [MASTER_QTY-1:0] pend;
    logic [MASTER_QTY-1:0] others;
    logic [SEL_W-1:0]      pick;
    logic [SEL_W-1:0]      cand;
    logic [SEL_W-1:0]      ptr_after_pick;

    // The CPU (index 0) never requests through req; it is the default owner.
    assign pend   = {req[MASTER_QTY-1:1], 1'b0};
    assign others = pend & ~(MASTER_QTY'(1) << msel);

    // Round-robin pick: lowest offset from ptr wins, so scan from the farthest candidate down
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int i = MASTER_QTY - 2; i >= 0; i--) begin
            cand = SEL_W'(((int'(ptr) - 1 + i) % (MASTER_QTY - 1)) + 1);
            if (pend[cand]) begin
                pick = cand;
            end
        end
        ptr_after_pick = (pick == SEL_W'(MASTER_QTY - 1)) ? SEL_W'(1) : pick + SEL_W'(1);
    end

    // Next-state and next-output logic; outputs are registered so values here land after the edge
    always_comb begin
        state_d    = state;
        grant_d    = grant;
        msel_d     = msel;
        busrqn_d   = busrqn;
        preempt_d  = 1'b0;
        hold_cnt_d = hold_cnt;
        ptr_d      = ptr;
        case (state)
            CPU_OWN: begin
                if (pend != '0 && busakn) begin
                    busrqn_d = 1'b0;
                    state_d  = RQ_CPU;
                end
            end
            RQ_CPU: begin
                // Keep BUSRQ asserted until the CPU has actually let go, even if the request vanished.
                if (!busakn) begin
                    if (pend != '0) begin
                        grant_d    = MASTER_QTY'(1) << pick;
                        msel_d     = pick;
                        hold_cnt_d = '0;
                        ptr_d      = ptr_after_pick;
                        state_d    = GRANT;
                    end else begin
                        busrqn_d = 1'b1;
                        state_d  = CPU_RETURN;
                    end
                end
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + CNT_W'(1);
                // A voluntary release takes precedence over a preemption firing the same cycle.
                if (!req[msel]) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end else if (hold_cnt == HOLD_LAST && others != '0) begin
                    grant_d   = '0;
                    preempt_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                // msel stays on the old master so it can finish its in-flight cycle.
                if (bus_mreqn && bus_iorqn) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (pend != '0) begin
                    grant_d    = MASTER_QTY'(1) << pick;
                    msel_d     = pick;
                    hold_cnt_d = '0;
                    ptr_d      = ptr_after_pick;
                    state_d    = GRANT;
                end else begin
                    msel_d   = '0;
                    busrqn_d = 1'b1;
                    state_d  = CPU_RETURN;
                end
            end
            CPU_RETURN: begin
                if (busakn) begin
                    state_d = CPU_OWN;
                end
            end
            default: begin
                grant_d  = '0;
                msel_d   = '0;
                busrqn_d = 1'b1;
                state_d  = CPU_OWN;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously to hand the bus back to the CPU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CPU_OWN;
            grant    <= '0;
            msel     <= '0;
            busrqn   <= 1'b1;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= SEL_W'(1);
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            msel     <= msel_d;
            busrqn   <= busrqn_d;
            preempt  <= preempt_d;
            hold_cnt <= hold_cnt_d;
            ptr      <= ptr_d;
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - directed and randomized checks of z80_bus_arbiter against a behavioural model
module tb_z80_bus_arbiter;
    localparam int N    = 3;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   msel;
    logic         busrqn;
    logic         busakn;
    logic         bus_mreqn;
    logic         bus_iorqn;
    logic         preempt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_bus_arbiter #(.MASTER_QTY(N), .MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .msel      (msel),
        .busrqn    (busrqn),
        .busakn    (busakn),
        .bus_mreqn (bus_mreqn),
        .bus_iorqn (bus_iorqn),
        .preempt   (preempt)
    );

    // Behavioural model: who owns the bus and what phase of the hand-over we are in
    localparam int PH_CPU   = 0;
    localparam int PH_ASK   = 1;
    localparam int PH_DMA   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_GAP   = 4;
    localparam int PH_BACK  = 5;

    int m_phase;
    int m_owner;
    int m_age;
    int m_next;
    int m_sel;
    bit m_rqn;
    bit m_pre;

    int ack_dly;
    int cpu_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_CPU;
        m_owner = -1;
        m_age   = 0;
        m_next  = 1;
        m_sel   = 0;
        m_rqn   = 1'b1;
        m_pre   = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] p);
        int c;
        for (int off = 0; off < N - 1; off++) begin
            c = ((m_next - 1 + off) % (N - 1)) + 1;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_award(input int k);
        m_owner = k;
        m_sel   = k;
        m_age   = 0;
        m_next  = (k == N - 1) ? 1 : k + 1;
        m_phase = PH_DMA;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic ak, input logic idle);
        logic [N-1:0] p;
        int  k;
        bit  rival;
        p     = r;
        p[0]  = 1'b0;
        m_pre = 1'b0;
        case (m_phase)
            PH_CPU: if (p != '0 && ak) begin
                m_rqn   = 1'b0;
                m_phase = PH_ASK;
            end
            PH_ASK: if (!ak) begin
                k = rr_pick(p);
                if (k > 0) model_award(k);
                else begin
                    m_rqn   = 1'b1;
                    m_phase = PH_BACK;
                end
            end
            PH_DMA: begin
                rival = 1'b0;
                for (int i = 1; i < N; i++) if (i != m_owner && p[i]) rival = 1'b1;
                if (!r[m_owner]) begin
                    m_owner = -1;
                    m_phase = PH_DRAIN;
                end else if (m_age >= HOLD - 1 && rival) begin
                    m_owner = -1;
                    m_pre   = 1'b1;
                    m_phase = PH_DRAIN;
                end
                m_age++;
            end
            PH_DRAIN: if (idle) m_phase = PH_GAP;
            PH_GAP: begin
                k = rr_pick(p);
                if (k > 0) model_award(k);
                else begin
                    m_sel   = 0;
                    m_rqn   = 1'b1;
                    m_phase = PH_BACK;
                end
            end
            PH_BACK: if (ak) m_phase = PH_CPU;
            default: m_phase = PH_CPU;
        endcase
    endtask

    task automatic compare_all();
        logic [N-1:0] g;
        g = '0;
        if (m_owner > 0) g[m_owner] = 1'b1;
        check("grant", 32'(grant), 32'(g));
        check("msel", 32'(msel), 32'(m_sel));
        check("busrqn", 32'(busrqn), 32'(m_rqn));
        check("preempt", 32'(preempt), 32'(m_pre));
    endtask

    // CPU side of BUSRQ/BUSAK: follows busrqn after ack_dly cycles
    task automatic cpu_react();
        if (busrqn == busakn) cpu_cnt = 0;
        else if (cpu_cnt >= ack_dly) begin
            busakn  = busrqn;
            cpu_cnt = 0;
        end else cpu_cnt++;
    endtask

    task automatic step();
        cpu_react();
        @(posedge clk);
        model_step(req, busakn, bus_mreqn & bus_iorqn);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        busakn    = 1'b1;
        bus_mreqn = 1'b1;
        bus_iorqn = 1'b1;
        cpu_cnt   = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic wait_grant(input int k, input int limit);
        int n;
        n = 0;
        while (!grant[k] && n < limit) begin
            step();
            n++;
        end
        check("wait_grant", 32'(grant[k]), 32'd1);
    endtask

    initial begin
        int n;
        ack_dly = 3;

        // single request then return to CPU
        do_reset();
        req = 3'b010;
        step();
        check("busrqn_fall", 32'(busrqn), 32'd0);
        wait_grant(1, 20);
        check("single_msel", 32'(msel), 32'd1);
        req = 3'b000;
        repeat (10) step();
        check("back_to_cpu_msel", 32'(msel), 32'd0);
        check("back_to_cpu_rqn", 32'(busrqn), 32'd1);

        // round robin with a one-cycle handoff gap
        do_reset();
        req = 3'b110;
        wait_grant(1, 20);
        req = 3'b100;
        n = 0;
        while (!grant[2] && n < 10) begin
            step();
            n++;
        end
        check("rr_handoff_cycles", 32'(n), 32'd3);
        req = 3'b110;
        repeat (3) step();
        req = 3'b010;
        wait_grant(1, 20);

        // preemption after HOLD cycles, then a lone holder is never preempted
        do_reset();
        req = 3'b010;
        wait_grant(1, 20);
        req = 3'b110;
        n = 0;
        while (grant[1] && n < 20) begin
            step();
            n++;
        end
        check("preempt_latency", 32'(n), 32'd8);
        check("preempt_pulse", 32'(preempt), 32'd1);
        step();
        check("preempt_one_cycle", 32'(preempt), 32'd0);
        req = 3'b100;
        wait_grant(2, 20);
        repeat (100) step();
        check("lone_holder", 32'(grant), 32'b100);

        // handoff waits for the bus to go idle
        do_reset();
        req = 3'b010;
        wait_grant(1, 20);
        bus_mreqn = 1'b0;
        req = 3'b100;
        repeat (6) step();
        check("drain_msel", 32'(msel), 32'd1);
        check("drain_grant", 32'(grant), 32'd0);
        bus_mreqn = 1'b1;
        wait_grant(2, 10);

        // request withdrawn while waiting for BUSAK
        do_reset();
        req = 3'b010;
        step();
        req = 3'b000;
        repeat (12) step();
        check("withdraw_rqn", 32'(busrqn), 32'd1);

        // asynchronous reset mid-tenure
        do_reset();
        req = 3'b100;
        wait_grant(2, 20);
        check("pre_reset_msel", 32'(msel), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("areset_grant", 32'(grant), 32'd0);
        check("areset_msel", 32'(msel), 32'd0);
        check("areset_busrqn", 32'(busrqn), 32'd1);
        @(negedge clk);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 1; i < N; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
            bus_mreqn = ($urandom_range(3) != 0);
            bus_iorqn = ($urandom_range(7) != 0);
            if (c % 50 == 0) ack_dly = $urandom_range(4);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
